// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result word reader:
// word layout, flag positions and condition codes.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    // Flag positions relative to WIDTH: overflow sits at the MSB.
    localparam int OVF_OFS   = 2;
    localparam int ZERO_OFS  = 1;
    localparam int CARRY_OFS = 0;

    localparam logic [2:0] COND_ALWAYS = 3'b000;
    localparam logic [2:0] COND_Z      = 3'b001;
    localparam logic [2:0] COND_NZ     = 3'b010;
    localparam logic [2:0] COND_C      = 3'b011;
    localparam logic [2:0] COND_NC     = 3'b100;
    localparam logic [2:0] COND_V      = 3'b101;
    localparam logic [2:0] COND_NV     = 3'b110;
    localparam logic [2:0] COND_NEVER  = 3'b111;

    function automatic logic cond_eval(
        input logic [2:0] sel,
        input logic       z,
        input logic       c,
        input logic       v
    );
        logic r;
        r = 1'b0;
        unique case (sel)
            COND_ALWAYS: r = 1'b1;
            COND_Z:      r = z;
            COND_NZ:     r = ~z;
            COND_C:      r = c;
            COND_NC:     r = ~c;
            COND_V:      r = v;
            COND_NV:     r = ~v;
            COND_NEVER:  r = 1'b0;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Small valid/ready FIFO holding packed ALU result words.
// Registered storage only; no bypass from input to output.
module word_fifo #(
    parameter int W     = 35,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_word,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_word,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    // Ready is held low during reset so nothing is accepted then.
    assign in_ready  = ~rst & (count < FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_word  = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_word_reader.sv
// Buffers packed ALU result words, unpacks the head entry,
// decodes a condition on it and keeps sticky consume statistics.
module alu_word_reader
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH+2:0] in_word,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_carry,
    input  logic [2:0]       cond_sel,
    output logic             out_cond,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       ovf_count,
    output logic             err_zero,
    input  logic             sticky_clr
);

    logic [WIDTH+2:0] head;
    logic             head_valid;
    logic             pop;
    logic             h_ovf;
    logic             h_zero;
    logic             h_carry;
    logic [WIDTH-1:0] h_data;

    word_fifo #(
        .W     (WIDTH + 3),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_word   (in_word),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_word  (head),
        .out_valid (head_valid),
        .out_ready (out_ready)
    );

    assign h_ovf   = head[WIDTH + OVF_OFS];
    assign h_zero  = head[WIDTH + ZERO_OFS];
    assign h_carry = head[WIDTH + CARRY_OFS];
    assign h_data  = head[WIDTH-1:0];
    assign pop     = head_valid & out_ready;

    // Everything presented downstream is forced to 0 without a valid head.
    assign out_valid    = head_valid;
    assign out_data     = head_valid ? h_data : '0;
    assign out_overflow = head_valid & h_ovf;
    assign out_zero     = head_valid & h_zero;
    assign out_carry    = head_valid & h_carry;
    assign out_cond     = head_valid & cond_eval(cond_sel, h_zero, h_carry, h_ovf);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= '0;
            err_zero  <= 1'b0;
        end else if (sticky_clr) begin
            ovf_count <= '0;
            err_zero  <= 1'b0;
        end else if (pop) begin
            if (h_ovf && ovf_count != 8'hFF) begin
                ovf_count <= ovf_count + 8'd1;
            end
            if (h_zero != (h_data == '0)) begin
                err_zero <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_word_reader.sv
// Directed self-checking bench for alu_word_reader.
// One task per scenario, each with its own inline checks.
module tb_alu_word_reader;

    localparam int WIDTH = 32;

    logic              clk;
    logic              rst;
    logic [WIDTH+2:0]  in_word;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  out_data;
    logic              out_overflow;
    logic              out_zero;
    logic              out_carry;
    logic [2:0]        cond_sel;
    logic              out_cond;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        ovf_count;
    logic              err_zero;
    logic              sticky_clr;

    int checks;
    int errors;

    alu_word_reader #(.WIDTH(WIDTH), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_word      (in_word),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .out_carry    (out_carry),
        .cond_sel     (cond_sel),
        .out_cond     (out_cond),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .ovf_count    (ovf_count),
        .err_zero     (err_zero),
        .sticky_clr   (sticky_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH+2:0] mk(
        input logic o, input logic z, input logic c,
        input logic [WIDTH-1:0] d
    );
        return {o, z, c, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({in_ready, out_valid, out_cond, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_outs got rdy=%0b vld=%0b cond=%0b data=%0h exp 0",
                     in_ready, out_valid, out_cond, out_data);
        end
        checks++;
        if ({out_overflow, out_zero, out_carry, ovf_count, err_zero} !== '0) begin
            errors++;
            $display("FAIL reset_flags got o=%0b z=%0b c=%0b cnt=%0d err=%0b exp 0",
                     out_overflow, out_zero, out_carry, ovf_count, err_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got rdy=%0b vld=%0b exp rdy=1 vld=0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_single();
        in_word   = mk(1'b0, 1'b0, 1'b1, 32'h5);
        in_valid  = 1'b1;
        cond_sel  = 3'b011;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_carry !== 1'b1 || out_cond !== 1'b1
            || out_data !== 32'h5) begin
            errors++;
            $display("FAIL single_head got vld=%0b c=%0b cond=%0b data=%0h exp 1 1 1 5",
                     out_valid, out_carry, out_cond, out_data);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_cond !== 1'b0) begin
            errors++;
            $display("FAIL single_pop got vld=%0b data=%0h cond=%0b exp 0 0 0",
                     out_valid, out_data, out_cond);
        end
    endtask

    task automatic test_cond();
        logic [7:0] exp_cond;
        // Head word: overflow=1, zero=1, carry=0, data=0.
        exp_cond  = 8'b0011_0011;
        out_ready = 1'b0;
        in_word   = mk(1'b1, 1'b1, 1'b0, 32'h0);
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        for (int s = 0; s < 8; s++) begin
            cond_sel = 3'(s);
            #1;
            checks++;
            if (out_cond !== exp_cond[s]) begin
                errors++;
                $display("FAIL cond_sel%0d got %0b exp %0b", s, out_cond, exp_cond[s]);
            end
        end
        cond_sel = 3'b101;
        step();
        step();
        checks++;
        if (out_valid !== 1'b1 || out_overflow !== 1'b1 || out_zero !== 1'b1
            || out_carry !== 1'b0 || out_cond !== 1'b1) begin
            errors++;
            $display("FAIL cond_hold got vld=%0b o=%0b z=%0b c=%0b cond=%0b exp 1 1 1 0 1",
                     out_valid, out_overflow, out_zero, out_carry, out_cond);
        end
        cond_sel  = 3'b000;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_cond !== 1'b0 || ovf_count !== 8'd1) begin
            errors++;
            $display("FAIL cond_pop got vld=%0b cond=%0b ovf=%0d exp 0 0 1",
                     out_valid, out_cond, ovf_count);
        end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_word = mk(1'b0, 1'b0, 1'b0, 32'(i));
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_rdy%0d got %0b exp 1", i, in_ready);
            end
            step();
        end
        in_word = mk(1'b0, 1'b0, 1'b0, 32'd5);
        step();
        checks++;
        if (in_ready !== 1'b0 || out_data !== 32'd1) begin
            errors++;
            $display("FAIL fill_full got rdy=%0b head=%0h exp rdy=0 head=1",
                     in_ready, out_data);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            if (i >= 3) in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
                errors++;
                $display("FAIL fill_order%0d got vld=%0b data=%0h exp 1 %0h",
                         i, out_valid, out_data, i);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_empty got %0b exp 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_word   = mk(1'b0, 1'b0, 1'b0, 32'd100);
        step();
        in_word   = mk(1'b0, 1'b0, 1'b0, 32'd101);
        step();
        out_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            in_word = mk(1'b0, 1'b0, 1'b0, 32'(102 + j));
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== 32'(100 + j)) begin
                errors++;
                $display("FAIL b2b%0d got vld=%0b rdy=%0b data=%0d exp 1 1 %0d",
                         j, out_valid, in_ready, out_data, 100 + j);
            end
            step();
        end
        in_valid = 1'b0;
        for (int j = 110; j < 112; j++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'(j)) begin
                errors++;
                $display("FAIL b2b_drain got vld=%0b data=%0d exp 1 %0d",
                         out_valid, out_data, j);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty got %0b exp 0", out_valid);
        end
    endtask

    task automatic test_ovf_sat();
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        checks++;
        if (ovf_count !== 8'd0) begin
            errors++;
            $display("FAIL ovf_clr0 got %0d exp 0", ovf_count);
        end
        in_word   = mk(1'b1, 1'b0, 1'b0, 32'hAB);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k == 11) begin
                checks++;
                if (ovf_count !== 8'd10) begin
                    errors++;
                    $display("FAIL ovf_mid got %0d exp 10", ovf_count);
                end
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (ovf_count !== 8'd255 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sat got cnt=%0d vld=%0b exp 255 0", ovf_count, out_valid);
        end
        in_valid = 1'b1;
        step();
        in_valid   = 1'b0;
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        checks++;
        if (ovf_count !== 8'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr_pop got cnt=%0d vld=%0b exp 0 0", ovf_count, out_valid);
        end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (ovf_count !== 8'd1) begin
            errors++;
            $display("FAIL ovf_after_clr got %0d exp 1", ovf_count);
        end
    endtask

    task automatic test_err_zero();
        out_ready = 1'b1;
        checks++;
        if (err_zero !== 1'b0) begin
            errors++;
            $display("FAIL err_init got %0b exp 0", err_zero);
        end
        in_word  = mk(1'b0, 1'b1, 1'b0, 32'h1);
        in_valid = 1'b1;
        step();
        in_word  = mk(1'b0, 1'b0, 1'b0, 32'h7);
        step();
        checks++;
        if (err_zero !== 1'b1) begin
            errors++;
            $display("FAIL err_set got %0b exp 1", err_zero);
        end
        in_word = mk(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (err_zero !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_hold got err=%0b vld=%0b exp 1 0", err_zero, out_valid);
        end
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        checks++;
        if (err_zero !== 1'b0 || ovf_count !== 8'd0) begin
            errors++;
            $display("FAIL err_clr got err=%0b ovf=%0d exp 0 0", err_zero, ovf_count);
        end
    endtask

    task automatic test_async_reset();
        in_word  = mk(1'b1, 1'b0, 1'b0, 32'h77);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (ovf_count !== 8'd1) begin
            errors++;
            $display("FAIL rst_pre_ovf got %0d exp 1", ovf_count);
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_word = mk(1'b0, 1'b0, 1'b0, 32'(16'h11 + i));
            step();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || ovf_count !== 8'd0
            || out_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_async got vld=%0b rdy=%0b ovf=%0d data=%0h exp 0 0 0 0",
                     out_valid, in_ready, ovf_count, out_data);
        end
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_stale%0d got vld=%0b rdy=%0b exp 0 1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        in_word    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        cond_sel   = 3'b000;
        sticky_clr = 1'b0;
        test_reset();
        test_single();
        test_cond();
        test_fill();
        test_back_to_back();
        test_ovf_sat();
        test_err_zero();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
